// File: rtl/post_lna_sequencer.sv
// Shares the PostLNA differential chain between receive and transmit: arbitrates, ramps stage
// biases with settle delays, drains with a guard interval. Optional fairness preemption: PLNA_FAIRNESS_EN.
module post_lna_sequencer #(
    parameter int unsigned STAGES        = 5,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned GUARD_CYCLES  = 4,
    parameter int unsigned MAX_HOLD      = 64
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              RxReq,
    input  logic              TxReq,
    output logic              RxGrant,
    output logic              TxGrant,
    output logic [STAGES-1:0] StageEnable,
    output logic              PathDir,
    output logic              Busy,
    output logic              Preempted
);

    localparam int unsigned SG_MAX  = (SETTLE_CYCLES > GUARD_CYCLES) ? SETTLE_CYCLES : GUARD_CYCLES;
    localparam int unsigned CNT_LIM = (SG_MAX > MAX_HOLD) ? SG_MAX : MAX_HOLD;
    localparam int unsigned CNT_W   = $clog2(CNT_LIM + 1);
    localparam int unsigned IDX_W   = $clog2(STAGES);

    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(CNT_LIM);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(STAGES - 1);

    typedef enum logic [1:0] {IDLE, RAMP, ACTIVE, DRAIN} seqStateT;

    seqStateT          state, stateNxt;
    logic [CNT_W-1:0]  cnt, cntNxt, cntInc;
    logic [IDX_W-1:0]  idx, idxNxt;
    logic              ownerTx, ownerTxNxt;
    logic              lastTx, lastTxNxt;
    logic              ownReq;
    logic [STAGES-1:0] rampMask;

`ifdef PLNA_FAIRNESS_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    logic otherReq;
    logic preemptHit, preemptNxt;
`endif

    // State and datapath registers
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            ownerTx <= 1'b0;
            lastTx  <= 1'b1;
`ifdef PLNA_FAIRNESS_EN
            preemptHit <= 1'b0;
`endif
        end else begin
            state   <= stateNxt;
            cnt     <= cntNxt;
            idx     <= idxNxt;
            ownerTx <= ownerTxNxt;
            lastTx  <= lastTxNxt;
`ifdef PLNA_FAIRNESS_EN
            preemptHit <= preemptNxt;
`endif
        end
    end

    // Next-state: arbitration, ramp stepping, release and guard timing
    always_comb begin
        stateNxt   = state;
        cntNxt     = cnt;
        idxNxt     = idx;
        ownerTxNxt = ownerTx;
        lastTxNxt  = lastTx;
        cntInc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        ownReq     = ownerTx ? TxReq : RxReq;
`ifdef PLNA_FAIRNESS_EN
        otherReq   = ownerTx ? RxReq : TxReq;
        preemptNxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (RxReq || TxReq) begin
                    ownerTxNxt = (RxReq && TxReq) ? ~lastTx : TxReq;
                    lastTxNxt  = ownerTxNxt;
                    stateNxt   = RAMP;
                    cntNxt     = '0;
                    idxNxt     = '0;
                end
            end
            RAMP: begin
                if (!ownReq) begin
                    stateNxt = DRAIN;
                    cntNxt   = '0;
                end else if (cnt == SETTLE_LAST) begin
                    cntNxt = '0;
                    if (idx == IDX_LAST) begin
                        stateNxt = ACTIVE;
                    end else begin
                        idxNxt = idx + IDX_W'(1);
                    end
                end else begin
                    cntNxt = cntInc;
                end
            end
            ACTIVE: begin
                if (!ownReq) begin
                    stateNxt = DRAIN;
                    cntNxt   = '0;
                end
`ifdef PLNA_FAIRNESS_EN
                else if (otherReq) begin
                    if (cnt == HOLD_LAST) begin
                        stateNxt   = DRAIN;
                        cntNxt     = '0;
                        preemptNxt = 1'b1;
                    end else begin
                        cntNxt = cntInc;
                    end
                end else begin
                    cntNxt = '0;
                end
`endif
            end
            DRAIN: begin
                if (cnt == GUARD_LAST) begin
                    stateNxt = IDLE;
                end else begin
                    cntNxt = cntInc;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    // Stages enabled so far: receive fills from the Vss end, transmit from the Vdd end
    always_comb begin
        rampMask = '0;
        for (int i = 0; i < STAGES; i++) begin
            rampMask[i] = ownerTx ? (IDX_W'(i) >= (IDX_LAST - idx)) : (IDX_W'(i) <= idx);
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            RxGrant     <= 1'b0;
            TxGrant     <= 1'b0;
            StageEnable <= '0;
            PathDir     <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            RxGrant     <= (state == ACTIVE) && !ownerTx;
            TxGrant     <= (state == ACTIVE) && ownerTx;
            StageEnable <= (state == ACTIVE) ? '1 : ((state == RAMP) ? rampMask : '0);
            PathDir     <= ownerTx;
            Busy        <= (state != IDLE);
        end
    end

`ifdef PLNA_FAIRNESS_EN
    // Delayed one cycle so the pulse lines up with the grant dropping
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            Preempted <= 1'b0;
        end else begin
            Preempted <= preemptHit;
        end
    end
`else
    assign Preempted = 1'b0;
`endif

endmodule

// File: tb/tb_post_lna_sequencer.sv
// Bench for post_lna_sequencer: directed vector table plus random requests checked against a
// timeline model that derives outputs from arbitration/release edge times.
module tb_post_lna_sequencer;

    localparam int STAGES   = 5;
    localparam int SETTLE   = 8;
    localparam int GUARD    = 4;
    localparam int MAX_HOLD = 64;

    logic              Clock;
    logic              ResetN;
    logic              RxReq;
    logic              TxReq;
    logic              RxGrant;
    logic              TxGrant;
    logic [STAGES-1:0] StageEnable;
    logic              PathDir;
    logic              Busy;
    logic              Preempted;
    logic [31:0]       obs;

    post_lna_sequencer #(
        .STAGES       (STAGES),
        .SETTLE_CYCLES(SETTLE),
        .GUARD_CYCLES (GUARD),
        .MAX_HOLD     (MAX_HOLD)
    ) dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .RxReq      (RxReq),
        .TxReq      (TxReq),
        .RxGrant    (RxGrant),
        .TxGrant    (TxGrant),
        .StageEnable(StageEnable),
        .PathDir    (PathDir),
        .Busy       (Busy),
        .Preempted  (Preempted)
    );

    assign obs = 32'({RxGrant, TxGrant, StageEnable, PathDir, Busy, Preempted});

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int fails  = 0;

    // Timeline model: mode 0 idle, 1 owned (ramping or granted), 2 draining
    int   mMode;
    int   mWin;
    int   mDrain;
    int   mWait;
    int   mCyc;
    logic mOwnTx;
    logic mLastTx;
    logic mPre;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, mCyc);
        end
    endtask

    task automatic modelReset();
        mMode   = 0;
        mWin    = 0;
        mDrain  = 0;
        mWait   = 0;
        mCyc    = 0;
        mOwnTx  = 1'b0;
        mLastTx = 1'b1;
        mPre    = 1'b0;
    endtask

    // Outputs visible after edge mCyc, derived from the model as it stood after the previous edge
    function automatic logic [31:0] modelExp();
        int                e;
        int                bits;
        logic              rg;
        logic              tg;
        logic              pr;
        logic              bz;
        logic [STAGES-1:0] se;
        e  = mCyc - 1;
        se = '0;
        rg = 1'b0;
        tg = 1'b0;
        pr = 1'b0;
        bz = (mMode != 0);
        if (mMode == 1) begin
            bits = (e - mWin) / SETTLE + 1;
            if (bits > STAGES) bits = STAGES;
            for (int i = 0; i < bits; i++) begin
                if (mOwnTx) se[STAGES-1-i] = 1'b1;
                else        se[i] = 1'b1;
            end
            if (e - mWin >= STAGES * SETTLE) begin
                rg = !mOwnTx;
                tg = mOwnTx;
            end
        end
        if (mMode == 2 && mPre && e == mDrain) pr = 1'b1;
        return 32'({rg, tg, se, mOwnTx, bz, pr});
    endfunction

    task automatic modelEdge(input logic rx, input logic tx);
        int   n;
        logic own;
        logic oth;
        n   = mCyc;
        own = mOwnTx ? tx : rx;
        oth = mOwnTx ? rx : tx;
        case (mMode)
            0: begin
                if (rx || tx) begin
                    mOwnTx  = (rx && tx) ? !mLastTx : tx;
                    mLastTx = mOwnTx;
                    mMode   = 1;
                    mWin    = n;
                    mWait   = 0;
                end
            end
            1: begin
                if (!own) begin
                    mMode  = 2;
                    mDrain = n;
                    mPre   = 1'b0;
                end
`ifdef PLNA_FAIRNESS_EN
                else if (n - 1 >= mWin + STAGES * SETTLE) begin
                    mWait = oth ? mWait + 1 : 0;
                    if (mWait == MAX_HOLD) begin
                        mMode  = 2;
                        mDrain = n;
                        mPre   = 1'b1;
                    end
                end
`else
                else if (oth) mWait = mWait + 1;
`endif
            end
            default: begin
                if (n - mDrain == GUARD) mMode = 0;
            end
        endcase
        mCyc++;
    endtask

    task automatic step();
        logic [31:0] exp;
        exp = modelExp();
        @(posedge Clock);
        modelEdge(RxReq, TxReq);
        #1;
        check("model", obs, exp);
    endtask

    typedef struct {
        logic       rx;
        logic       tx;
        int         n;
        logic       rg;
        logic       tg;
        logic [4:0] se;
        logic       dir;
        logic       busy;
    } vecT;

    function automatic vecT mk(input logic rx, input logic tx, input int n, input logic rg,
                               input logic tg, input logic [4:0] se, input logic dir, input logic busy);
        vecT v;
        v.rx = rx; v.tx = tx; v.n = n; v.rg = rg; v.tg = tg; v.se = se; v.dir = dir; v.busy = busy;
        return v;
    endfunction

    vecT vec[$];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int   preCount;
        int   rxLow;
        vecT  v;

        // rx, tx, edges held, then expected RxGrant, TxGrant, StageEnable, PathDir, Busy
        vec.push_back(mk(1, 0,  2, 0, 0, 5'b00001, 0, 1));
        vec.push_back(mk(1, 0,  8, 0, 0, 5'b00011, 0, 1));
        vec.push_back(mk(1, 0, 24, 0, 0, 5'b11111, 0, 1));
        vec.push_back(mk(1, 0,  7, 0, 0, 5'b11111, 0, 1));
        vec.push_back(mk(1, 0,  1, 1, 0, 5'b11111, 0, 1));
        vec.push_back(mk(0, 0,  1, 1, 0, 5'b11111, 0, 1));
        vec.push_back(mk(0, 0,  1, 0, 0, 5'b00000, 0, 1));
        vec.push_back(mk(0, 0,  3, 0, 0, 5'b00000, 0, 1));
        vec.push_back(mk(0, 0,  1, 0, 0, 5'b00000, 0, 0));
        vec.push_back(mk(0, 1,  2, 0, 0, 5'b10000, 1, 1));
        vec.push_back(mk(0, 1,  8, 0, 0, 5'b11000, 1, 1));
        vec.push_back(mk(0, 1, 32, 0, 1, 5'b11111, 1, 1));
        vec.push_back(mk(0, 0,  2, 0, 0, 5'b00000, 1, 1));
        vec.push_back(mk(0, 0,  4, 0, 0, 5'b00000, 1, 0));
        vec.push_back(mk(1, 1, 42, 1, 0, 5'b11111, 0, 1));
        vec.push_back(mk(0, 1,  2, 0, 0, 5'b00000, 0, 1));
        vec.push_back(mk(0, 1,  5, 0, 0, 5'b10000, 1, 1));
        vec.push_back(mk(0, 1, 40, 0, 1, 5'b11111, 1, 1));
        vec.push_back(mk(0, 0,  6, 0, 0, 5'b00000, 1, 0));
        vec.push_back(mk(1, 0, 21, 0, 0, 5'b00111, 0, 1));
        vec.push_back(mk(0, 0,  1, 0, 0, 5'b00111, 0, 1));
        vec.push_back(mk(0, 0,  1, 0, 0, 5'b00000, 0, 1));
        vec.push_back(mk(0, 0,  4, 0, 0, 5'b00000, 0, 0));
        vec.push_back(mk(1, 0,  1, 0, 0, 5'b00000, 0, 0));
        vec.push_back(mk(0, 0,  1, 0, 0, 5'b00001, 0, 1));
        vec.push_back(mk(0, 0,  1, 0, 0, 5'b00000, 0, 1));
        vec.push_back(mk(0, 0,  4, 0, 0, 5'b00000, 0, 0));

        ResetN = 1'b0;
        RxReq  = 1'b0;
        TxReq  = 1'b0;
        modelReset();
        #12;
        check("reset.RxGrant", 32'(RxGrant), 32'd0);
        check("reset.TxGrant", 32'(TxGrant), 32'd0);
        check("reset.StageEnable", 32'(StageEnable), 32'd0);
        check("reset.PathDir", 32'(PathDir), 32'd0);
        check("reset.Busy", 32'(Busy), 32'd0);
        check("reset.Preempted", 32'(Preempted), 32'd0);

        @(negedge Clock);
        ResetN = 1'b1;
        RxReq  = vec[0].rx;
        TxReq  = vec[0].tx;

        foreach (vec[i]) begin
            v     = vec[i];
            RxReq = v.rx;
            TxReq = v.tx;
            repeat (v.n) step();
            check($sformatf("row%0d.RxGrant", i), 32'(RxGrant), 32'(v.rg));
            check($sformatf("row%0d.TxGrant", i), 32'(TxGrant), 32'(v.tg));
            check($sformatf("row%0d.StageEnable", i), 32'(StageEnable), 32'(v.se));
            check($sformatf("row%0d.PathDir", i), 32'(PathDir), 32'(v.dir));
            check($sformatf("row%0d.Busy", i), 32'(Busy), 32'(v.busy));
        end

        // Asynchronous reset while granted, then a full ramp from scratch
        RxReq = 1'b1;
        repeat (50) step();
        check("preReset.RxGrant", 32'(RxGrant), 32'd1);
        #3;
        ResetN = 1'b0;
        #1;
        check("asyncReset.outputs", obs, 32'd0);
        modelReset();
        @(negedge Clock);
        ResetN = 1'b1;
        repeat (41) step();
        check("reramp.earlyGrant", 32'(RxGrant), 32'd0);
        step();
        check("reramp.grant", 32'(RxGrant), 32'd1);

        // Both sides held while receive owns the chain
        TxReq    = 1'b1;
        preCount = 0;
        rxLow    = 0;
        repeat (200) begin
            step();
            if (Preempted) preCount++;
            if (!RxGrant) rxLow++;
        end
`ifdef PLNA_FAIRNESS_EN
        check("fairness.preemptSeen", 32'(preCount > 0), 32'd1);
`else
        check("noFairness.rxLowCycles", 32'(rxLow), 32'd0);
        check("noFairness.preemptPulses", 32'(preCount), 32'd0);
`endif

        RxReq = 1'b0;
        TxReq = 1'b0;
        repeat (10) step();

        // Random request levels
        repeat (4000) begin
            if ($urandom_range(15) == 0) RxReq = ~RxReq;
            if ($urandom_range(15) == 0) TxReq = ~TxReq;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
